// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide issue scheduler.
//   sched_state_t : scheduler FSM states (IDLE, EXEC, WB)
//   F3_*          : RV32M funct3 encodings carried in instr[14:12]
//   is_div_op     : true for the divide/remainder group
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } sched_state_t;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  function automatic logic is_div_op(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/muldiv_pick.sv
// Combinational winner select for the mult/div issue scheduler.
// Policy is chosen at build time by MULDIV_OLDEST_FIRST_EN:
//   undefined : round-robin starting at rr_ptr, first valid index wins
//   defined   : smallest (req_rob - rob_head) mod ROB_DEPTH wins,
//               ties go to the lowest index; rr_ptr is ignored
// Ports:
//   req_valid [NUM_REQ]         requesting entries
//   req_rob   [NUM_REQ][TAG_W]  ROB tag per entry
//   rob_head  [TAG_W]           ROB head (age reference)
//   rr_ptr    [IDX_W]           round-robin search start
//   grant     [NUM_REQ]         one-hot winner (all zero if nobody valid)
//   winner    [IDX_W]           winner index
//   any_valid                   at least one entry requesting
module muldiv_pick #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_DEPTH = 4,
  localparam int TAG_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0] req_rob,
  input  logic [TAG_W-1:0]              rob_head,
  input  logic [IDX_W-1:0]              rr_ptr,
  output logic [NUM_REQ-1:0]            grant,
  output logic [IDX_W-1:0]              winner,
  output logic                          any_valid
);

  assign any_valid = |req_valid;

`ifdef MULDIV_OLDEST_FIRST_EN
  logic unused_rr;
  assign unused_rr = ^rr_ptr;

  always_comb begin
    int age;
    int best_age;
    grant    = '0;
    winner   = '0;
    age      = 0;
    best_age = ROB_DEPTH;
    // Strict less-than keeps the lowest index on equal ages.
    for (int i = 0; i < NUM_REQ; i++) begin
      age = (int'(req_rob[i]) - int'(rob_head) + ROB_DEPTH) % ROB_DEPTH;
      if (req_valid[i] && (age < best_age)) begin
        best_age = age;
        winner   = IDX_W'(i);
      end
    end
    if (any_valid) grant[winner] = 1'b1;
  end
`else
  logic unused_age;
  assign unused_age = ^{req_rob, rob_head};

  always_comb begin
    int   idx;
    logic found;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
    if (found) grant[winner] = 1'b1;
  end
`endif

endmodule

// File: rtl/muldiv_issue_sched.sv
// Issue scheduler for the shared multiply/divide unit.
// Picks one ready reservation-station entry, holds its operands on the
// unit_* bus for the whole operation, captures the result and holds it
// until the CDB accepts it. One op in flight; flush aborts everything.
// Build option: MULDIV_OLDEST_FIRST_EN selects oldest-first arbitration
// (default build is round-robin).
// Ports:
//   clk, rst (sync, active-high), flush
//   req_valid/req_instr/req_rs1_v/req_rs2_v/req_rob : RS entry requests
//   rob_head     : ROB head tag, age reference
//   req_grant    : one-hot, combinational in IDLE; entry dequeues
//   unit_en      : high every EXEC cycle
//   unit_instr/unit_rs1_v/unit_rs2_v/unit_rob : latched op
//   unit_flush   : flush pass-through
//   unit_resp/unit_result : one-cycle result from the unit
//   cdb_req/cdb_grant/cdb_result/cdb_rob : result broadcast handshake
//   busy         : scheduler not idle
module muldiv_issue_sched
  import muldiv_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ROB_DEPTH = 4,
  localparam int TAG_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][31:0]      req_instr,
  input  logic [NUM_REQ-1:0][31:0]      req_rs1_v,
  input  logic [NUM_REQ-1:0][31:0]      req_rs2_v,
  input  logic [NUM_REQ-1:0][TAG_W-1:0] req_rob,
  input  logic [TAG_W-1:0]              rob_head,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic                          unit_en,
  output logic [31:0]                   unit_instr,
  output logic [31:0]                   unit_rs1_v,
  output logic [31:0]                   unit_rs2_v,
  output logic [TAG_W-1:0]              unit_rob,
  output logic                          unit_flush,
  input  logic                          unit_resp,
  input  logic [31:0]                   unit_result,
  output logic                          cdb_req,
  input  logic                          cdb_grant,
  output logic [31:0]                   cdb_result,
  output logic [TAG_W-1:0]              cdb_rob,
  output logic                          busy
);

  sched_state_t       state;
  sched_state_t       state_next;
  logic               issue;
  logic               capture;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   rr_ptr;

  muldiv_pick #(
    .NUM_REQ   (NUM_REQ),
    .ROB_DEPTH (ROB_DEPTH)
  ) u_pick (
    .req_valid (req_valid),
    .req_rob   (req_rob),
    .rob_head  (rob_head),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .winner    (pick_idx),
    .any_valid (pick_any)
  );

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    capture    = 1'b0;
    cdb_req    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any && !flush && !rst) begin
          issue      = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        // A response landing in the flush cycle belongs to a killed op.
        if (flush) begin
          state_next = IDLE;
        end else if (unit_resp) begin
          capture    = 1'b1;
          state_next = WB;
        end
      end
      WB: begin
        cdb_req = !flush && !rst;
        if (flush || cdb_grant) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_grant  = issue ? pick_grant : '0;
  assign unit_en    = (state == EXEC);
  assign unit_flush = flush;
  assign busy       = (state != IDLE);
  // The tag travels with the op; the held result reuses it.
  assign cdb_rob    = unit_rob;

  // ---- issue / result capture registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      unit_instr <= '0;
      unit_rs1_v <= '0;
      unit_rs2_v <= '0;
      unit_rob   <= '0;
      cdb_result <= '0;
    end else begin
      state <= state_next;
      if (issue) begin
        unit_instr <= req_instr[pick_idx];
        unit_rs1_v <= req_rs1_v[pick_idx];
        unit_rs2_v <= req_rs2_v[pick_idx];
        unit_rob   <= req_rob[pick_idx];
      end
      if (capture) cdb_result <= unit_result;
    end
  end

`ifdef MULDIV_OLDEST_FIRST_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_issue_sched.sv
// Self-checking bench for muldiv_issue_sched (NUM_REQ=4, ROB_DEPTH=4).
// Works in both arbitration builds (MULDIV_OLDEST_FIRST_EN on/off).
module tb_muldiv_issue_sched;
  import muldiv_pkg::*;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0][31:0] req_instr;
  logic [3:0][31:0] req_rs1_v;
  logic [3:0][31:0] req_rs2_v;
  logic [3:0][1:0]  req_rob;
  logic [1:0]       rob_head;
  logic [3:0]       req_grant;
  logic             unit_en;
  logic [31:0]      unit_instr;
  logic [31:0]      unit_rs1_v;
  logic [31:0]      unit_rs2_v;
  logic [1:0]       unit_rob;
  logic             unit_flush;
  logic             unit_resp;
  logic [31:0]      unit_result;
  logic             cdb_req;
  logic             cdb_grant;
  logic [31:0]      cdb_result;
  logic [1:0]       cdb_rob;
  logic             busy;

  muldiv_issue_sched #(.NUM_REQ(4), .ROB_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_instr   (req_instr),
    .req_rs1_v   (req_rs1_v),
    .req_rs2_v   (req_rs2_v),
    .req_rob     (req_rob),
    .rob_head    (rob_head),
    .req_grant   (req_grant),
    .unit_en     (unit_en),
    .unit_instr  (unit_instr),
    .unit_rs1_v  (unit_rs1_v),
    .unit_rs2_v  (unit_rs2_v),
    .unit_rob    (unit_rob),
    .unit_flush  (unit_flush),
    .unit_resp   (unit_resp),
    .unit_result (unit_result),
    .cdb_req     (cdb_req),
    .cdb_grant   (cdb_grant),
    .cdb_result  (cdb_result),
    .cdb_rob     (cdb_rob),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: the entry data offered next, the round-robin
  // pointer, and the instruction last handed to the unit.
  logic [3:0][31:0] d_instr;
  logic [3:0][31:0] d_rs1;
  logic [3:0][31:0] d_rs2;
  logic [3:0][1:0]  d_rob;
  logic [1:0]       d_head;
  int               m_ptr = 0;
  logic [31:0]      prev_instr = '0;

  // What the fake unit returns for an op.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    p = '0;
    case (f3)
      F3_MUL:  return a * b;
      F3_MULH: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p[63:32];
      end
      F3_MULHU: begin
        p = {32'd0, a} * {32'd0, b};
        return p[63:32];
      end
      F3_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REMU: return (b == 32'd0) ? a : a % b;
      default: return a ^ b;
    endcase
  endfunction

  // Winner by the arbitration rule applied to the offered requests.
  function automatic int model_pick(input logic [3:0] v);
    int best;
    int best_age;
    int a;
    best = -1;
    best_age = 4;
    a = 0;
`ifdef MULDIV_OLDEST_FIRST_EN
    for (int i = 0; i < 4; i++) begin
      a = (int'(d_rob[i]) + 4 - int'(d_head)) % 4;
      if (v[i] && a < best_age) begin
        best_age = a;
        best = i;
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (best < 0 && v[(m_ptr + k) % 4]) best = (m_ptr + k) % 4;
    end
`endif
    return best;
  endfunction

  task automatic gen_data();
    for (int i = 0; i < 4; i++) begin
      d_instr[i] = $urandom;
      d_rs1[i]   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 100));
      d_rs2[i]   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      d_rob[i]   = 2'($urandom);
    end
    d_head = 2'($urandom);
  endtask

  task automatic scramble_reqs();
    req_valid = 4'($urandom);
    rob_head  = 2'($urandom);
    for (int i = 0; i < 4; i++) begin
      req_instr[i] = $urandom;
      req_rs1_v[i] = $urandom;
      req_rs2_v[i] = $urandom;
      req_rob[i]   = 2'($urandom);
    end
  endtask

  // One operation: grant, lat+1 EXEC cycles (resp on the last), then
  // stall+1 WB cycles (cdb_grant on the last).
  // fmode: 0 none, 1 flush mid-EXEC, 2 flush with unit_resp,
  //        3 flush in WB, 4 flush together with cdb_grant.
  task automatic run_op(input logic [3:0] v, input int lat, input int stall, input int fmode,
                        output logic [3:0] g_out, output logic [31:0] res_obs);
    int          w;
    logic [31:0] e_instr, e_rs1, e_rs2, res;
    logic [1:0]  e_rob;
    logic        fl;
    @(negedge clk);
    req_valid = v;
    req_instr = d_instr;
    req_rs1_v = d_rs1;
    req_rs2_v = d_rs2;
    req_rob   = d_rob;
    rob_head  = d_head;
    flush     = 1'b0;
    unit_resp = 1'b0;
    cdb_grant = 1'b0;
    #1;
    w = model_pick(v);
    g_out = req_grant;
    res_obs = '0;
    check_eq("grant", 32'(req_grant), 32'd1 << w);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_cdb_req", 32'(cdb_req), 32'd0);
    check_eq("idle_unit_en", 32'(unit_en), 32'd0);
    check_eq("idle_hold_instr", unit_instr, prev_instr);
    e_instr = d_instr[w];
    e_rs1   = d_rs1[w];
    e_rs2   = d_rs2[w];
    e_rob   = d_rob[w];
    res     = ref_op(e_instr[14:12], e_rs1, e_rs2);
    prev_instr = e_instr;
`ifndef MULDIV_OLDEST_FIRST_EN
    m_ptr = (w + 1) % 4;
`endif
    fl = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      scramble_reqs();
      unit_resp   = (c == lat);
      unit_result = (c == lat) ? res : $urandom;
      flush       = (fmode == 2 && c == lat);
      if (fmode == 1 && c == lat / 2) begin
        flush     = 1'b1;
        unit_resp = 1'b0;
      end
      #1;
      check_eq("exec_unit_en", 32'(unit_en), 32'd1);
      check_eq("exec_instr", unit_instr, e_instr);
      check_eq("exec_rs1", unit_rs1_v, e_rs1);
      check_eq("exec_rs2", unit_rs2_v, e_rs2);
      check_eq("exec_rob", 32'(unit_rob), 32'(e_rob));
      check_eq("exec_no_grant", 32'(req_grant), 32'd0);
      check_eq("exec_busy", 32'(busy), 32'd1);
      check_eq("exec_cdb_req", 32'(cdb_req), 32'd0);
      check_eq("unit_flush", 32'(unit_flush), 32'(flush));
      if (flush) begin
        fl = 1'b1;
        break;
      end
      if (unit_resp) break;
    end
    if (!fl) begin
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        scramble_reqs();
        unit_resp   = 1'b0;
        unit_result = $urandom;
        cdb_grant   = (s == stall) && (fmode != 3);
        flush       = (s == stall) && (fmode == 3 || fmode == 4);
        #1;
        check_eq("wb_cdb_req", 32'(cdb_req), 32'(!flush));
        check_eq("wb_cdb_result", cdb_result, res);
        check_eq("wb_cdb_rob", 32'(cdb_rob), 32'(e_rob));
        check_eq("wb_busy", 32'(busy), 32'd1);
        check_eq("wb_no_grant", 32'(req_grant), 32'd0);
        check_eq("wb_unit_en", 32'(unit_en), 32'd0);
        check_eq("wb_hold_instr", unit_instr, e_instr);
        check_eq("wb_hold_rs1", unit_rs1_v, e_rs1);
        res_obs = cdb_result;
      end
    end
  endtask

  logic [3:0]  g;
  logic [31:0] r;
  logic [3:0]  v;
  logic [3:0]  rr_tab [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    req_valid = 4'hF;
    req_instr = '0;
    req_rs1_v = '0;
    req_rs2_v = '0;
    req_rob = '0;
    rob_head = '0;
    unit_resp = 1'b0;
    unit_result = '0;
    cdb_grant = 1'b0;

    // Reset: all outputs zero even with requests pending.
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_grant", 32'(req_grant), 32'd0);
    check_eq("rst_unit_en", 32'(unit_en), 32'd0);
    check_eq("rst_unit_instr", unit_instr, 32'd0);
    check_eq("rst_unit_rs1", unit_rs1_v, 32'd0);
    check_eq("rst_unit_rs2", unit_rs2_v, 32'd0);
    check_eq("rst_unit_rob", 32'(unit_rob), 32'd0);
    check_eq("rst_unit_flush", 32'(unit_flush), 32'd0);
    check_eq("rst_cdb_req", 32'(cdb_req), 32'd0);
    check_eq("rst_cdb_result", cdb_result, 32'd0);
    check_eq("rst_cdb_rob", 32'(cdb_rob), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'h0;

`ifdef MULDIV_OLDEST_FIRST_EN
    // Oldest-first: head=2, tags {3,0,2,1}; granted entries drop out.
    d_head = 2'd2;
    d_rob[0] = 2'd3;
    d_rob[1] = 2'd0;
    d_rob[2] = 2'd2;
    d_rob[3] = 2'd1;
    v = 4'hF;
    for (int i = 0; i < 4; i++) begin
      run_op(v, 0, 0, 0, g, r);
      v = v & ~g;
    end
`else
    // Round-robin fairness with every entry requesting.
    for (int i = 0; i < 5; i++) begin
      gen_data();
      run_op(4'hF, 0, 0, 0, g, r);
      check_eq("rr_seq", 32'(g), 32'(rr_tab[i]));
    end
`endif

    // Basic MUL 3*5 from entry 0.
    gen_data();
    d_instr[0] = 32'h0200_0033;
    d_rs1[0] = 32'd3;
    d_rs2[0] = 32'd5;
    d_rob[0] = 2'd1;
    run_op(4'b0001, 3, 0, 0, g, r);
    check_eq("basic_grant", 32'(g), 32'd1);
    check_eq("basic_result", r, 32'd15);

    // CDB stalled for 10 cycles.
    gen_data();
    run_op(4'b0010, 2, 10, 0, g, r);

    // Flush together with unit_resp, then an op granted right after.
    gen_data();
    run_op(4'b0100, 2, 0, 2, g, r);
    gen_data();
    run_op(4'b1010, 1, 1, 0, g, r);

    // Random traffic with every flush flavour mixed in.
    for (int i = 0; i < 80; i++) begin
      int fsel;
      fsel = $urandom_range(0, 9);
      gen_data();
      run_op(4'($urandom_range(1, 15)), $urandom_range(0, 5), $urandom_range(0, 4),
             (fsel < 6) ? 0 : fsel - 5, g, r);
    end

    @(negedge clk);
    req_valid = '0;
    flush = 1'b0;
    cdb_grant = 1'b0;
    unit_resp = 1'b0;
    #1;
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("end_cdb_req", 32'(cdb_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
